// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM pipeline register with valid/ready, 2-entry skid buffer, flush and branch decode.
module ex_mem_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_CTRL_W  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [2:0]            memControlInput,
  input  logic [WB_CTRL_W-1:0]  wbControlInput,
  input  logic [DATA_W-1:0]     aluResultInput,
  input  logic                  aluZeroInput,
  input  logic [DATA_W-1:0]     pcInput,
  input  logic [DATA_W-1:0]     registerDataInput,
  input  logic [REG_ADDR_W-1:0] writeRegisterInput,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  branch,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [WB_CTRL_W-1:0]  wbControl,
  output logic [DATA_W-1:0]     aluResult,
  output logic                  aluZero,
  output logic [DATA_W-1:0]     pc,
  output logic [DATA_W-1:0]     registerData,
  output logic [REG_ADDR_W-1:0] writeRegister,
  output logic                  branchTaken
);
  localparam int PW = 3 + WB_CTRL_W + 3 * DATA_W + 1 + REG_ADDR_W;
  logic          m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [PW-1:0] m_q, m_d, s_q, s_d, in_w;
  logic          accept, consume;
  logic [2:0]    mc_w;
  logic [WB_CTRL_W-1:0] wb_w;
  assign in_w    = {memControlInput, wbControlInput, aluResultInput, aluZeroInput,
                    pcInput, registerDataInput, writeRegisterInput};
  assign inReady = !s_valid_q;
  assign accept  = inValid & inReady;
  assign consume = m_valid_q & outReady;
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || consume) begin
      m_valid_d = s_valid_q | accept;
      m_d       = s_valid_q ? s_q : (accept ? in_w : m_q);
      s_valid_d = 1'b0;
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_d       = in_w;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_q       <= m_d;
      s_q       <= s_d;
    end
  end
  assign {mc_w, wb_w, aluResult, aluZero, pc, registerData, writeRegister} = m_q;
  // Control gated so a bubble can never write memory or the register file.
  assign outValid    = m_valid_q;
  assign branch      = m_valid_q & mc_w[2];
  assign memRead     = m_valid_q & mc_w[1];
  assign memWrite    = m_valid_q & mc_w[0];
  assign wbControl   = m_valid_q ? wb_w : '0;
  assign branchTaken = m_valid_q & mc_w[2] & aluZero;
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: directed bench with a 2-deep FIFO reference model and literal spot checks.
module tb_ex_mem_pipe_reg;
  typedef struct packed {
    logic [2:0]  mc;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic        z;
    logic [31:0] pc;
    logic [31:0] rd;
    logic [4:0]  wr;
  } ent_t;

  logic clock = 0, reset = 1, flush = 0, inValid = 0, outReady = 0;
  logic [2:0]  memControlInput = 0;
  logic [1:0]  wbControlInput = 0;
  logic [31:0] aluResultInput = 0, pcInput = 0, registerDataInput = 0;
  logic        aluZeroInput = 0;
  logic [4:0]  writeRegisterInput = 0;
  logic inReady, outValid, branch, memRead, memWrite, aluZero, branchTaken;
  logic [1:0]  wbControl;
  logic [31:0] aluResult, pc, registerData;
  logic [4:0]  writeRegister;

  logic        v64 = 0;
  logic [63:0] rd64_in = 0;
  logic [5:0]  wr64_in = 0;
  logic        r64, ov64, br64, mr64, mw64, z64, bt64;
  logic [1:0]  wb64;
  logic [63:0] alu64, pc64, rd64;
  logic [5:0]  wr64;

  int tests = 0, fails = 0;
  ent_t q[$];

  always #5 clock = ~clock;

  ex_mem_pipe_reg dut (
    .clock(clock), .reset(reset), .flush(flush), .inValid(inValid), .inReady(inReady),
    .memControlInput(memControlInput), .wbControlInput(wbControlInput),
    .aluResultInput(aluResultInput), .aluZeroInput(aluZeroInput), .pcInput(pcInput),
    .registerDataInput(registerDataInput), .writeRegisterInput(writeRegisterInput),
    .outValid(outValid), .outReady(outReady), .branch(branch), .memRead(memRead),
    .memWrite(memWrite), .wbControl(wbControl), .aluResult(aluResult), .aluZero(aluZero),
    .pc(pc), .registerData(registerData), .writeRegister(writeRegister),
    .branchTaken(branchTaken));

  ex_mem_pipe_reg #(.DATA_W(64), .REG_ADDR_W(6), .WB_CTRL_W(2)) dut64 (
    .clock(clock), .reset(reset), .flush(1'b0), .inValid(v64), .inReady(r64),
    .memControlInput(3'b0), .wbControlInput(2'b0), .aluResultInput(64'd0),
    .aluZeroInput(1'b0), .pcInput(64'd0), .registerDataInput(rd64_in),
    .writeRegisterInput(wr64_in), .outValid(ov64), .outReady(1'b1), .branch(br64),
    .memRead(mr64), .memWrite(mw64), .wbControl(wb64), .aluResult(alu64), .aluZero(z64),
    .pc(pc64), .registerData(rd64), .writeRegister(wr64), .branchTaken(bt64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the block behaves as a 2-deep FIFO whose head drives the outputs.
  always @(posedge clock or posedge reset) begin
    if (reset || flush) q.delete();
    else begin
      automatic bit acc = inValid && q.size() < 2;
      if (q.size() > 0 && outReady) void'(q.pop_front());
      if (acc) q.push_back({memControlInput, wbControlInput, aluResultInput, aluZeroInput,
                            pcInput, registerDataInput, writeRegisterInput});
    end
  end

  always @(negedge clock) if (!reset) begin
    automatic bit ev = q.size() > 0;
    automatic ent_t e = ev ? q[0] : '0;
    chk("outValid", 64'(outValid), 64'(ev));
    chk("inReady", 64'(inReady), 64'(q.size() < 2));
    chk("branch", 64'(branch), 64'(ev & e.mc[2]));
    chk("memRead", 64'(memRead), 64'(ev & e.mc[1]));
    chk("memWrite", 64'(memWrite), 64'(ev & e.mc[0]));
    chk("wbControl", 64'(wbControl), 64'(ev ? e.wb : 2'b0));
    chk("branchTaken", 64'(branchTaken), 64'(ev & e.mc[2] & e.z));
    if (ev) begin
      chk("aluResult", 64'(aluResult), 64'(e.alu));
      chk("aluZero", 64'(aluZero), 64'(e.z));
      chk("pc", 64'(pc), 64'(e.pc));
      chk("registerData", 64'(registerData), 64'(e.rd));
      chk("writeRegister", 64'(writeRegister), 64'(e.wr));
    end
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] mc, input logic [1:0] wb,
                       input logic [31:0] alu, input logic z, input logic [31:0] p);
    inValid = v; memControlInput = mc; wbControlInput = wb; aluResultInput = alu;
    aluZeroInput = z; pcInput = p; registerDataInput = alu ^ 32'hA5A5_0000;
    writeRegisterInput = alu[4:0] + 5'd3;
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_outValid", 64'(outValid), 64'd0);
    chk("reset_aluResult", 64'(aluResult), 64'd0);
    reset = 0;
    tick();
    chk("post_reset_inReady", 64'(inReady), 64'd1);
    // Streaming
    outReady = 1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 3'b010, 2'b01, 32'(i), 0, 32'h100 + 32'(i));
      tick();
      chk("stream_valid", 64'(outValid), 64'd1);
      chk("stream_alu", 64'(aluResult), 64'(i));
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("stream_drain", 64'(outValid), 64'd0);
    // Stall and skid
    outReady = 0;
    drive(1, 3'b001, 2'b10, 32'h10, 0, 0);
    tick();
    chk("skid_ready_A", 64'(inReady), 64'd1);
    drive(1, 3'b001, 2'b10, 32'h20, 0, 0);
    tick();
    chk("skid_ready_B", 64'(inReady), 64'd0);
    chk("skid_head_A", 64'(aluResult), 64'h10);
    drive(1, 3'b001, 2'b10, 32'h99, 0, 0);
    tick();
    chk("skid_hold_A", 64'(aluResult), 64'h10);
    drive(0, 0, 0, 0, 0, 0);
    outReady = 1;
    tick();
    chk("skid_out_B", 64'(aluResult), 64'h20);
    chk("skid_ready_again", 64'(inReady), 64'd1);
    tick();
    chk("skid_empty", 64'(outValid), 64'd0);
    // Flush with both entries full
    outReady = 0;
    drive(1, 3'b001, 2'b11, 32'hA, 0, 0);
    tick();
    drive(1, 3'b001, 2'b11, 32'hB, 0, 0);
    tick();
    flush = 1;
    drive(1, 3'b001, 2'b11, 32'hC, 0, 0);
    tick();
    flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    chk("flush_outValid", 64'(outValid), 64'd0);
    chk("flush_memWrite", 64'(memWrite), 64'd0);
    chk("flush_wb", 64'(wbControl), 64'd0);
    chk("flush_inReady", 64'(inReady), 64'd1);
    outReady = 1;
    tick();
    chk("flush_no_C", 64'(outValid), 64'd0);
    // Branch decode
    drive(1, 3'b100, 2'b00, 32'h0, 1, 32'h40);
    tick();
    chk("br_taken", 64'(branchTaken), 64'd1);
    chk("br_pc", 64'(pc), 64'h40);
    drive(1, 3'b100, 2'b00, 32'h5, 0, 32'h44);
    tick();
    chk("br_not_taken", 64'(branchTaken), 64'd0);
    chk("br_branch", 64'(branch), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    // Reset mid-stream with M and S full
    outReady = 0;
    drive(1, 3'b001, 2'b01, 32'h55, 0, 0);
    tick();
    drive(1, 3'b001, 2'b01, 32'h66, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_reset_inReady", 64'(inReady), 64'd0);
    #1 reset = 1;
    #1;
    chk("async_outValid", 64'(outValid), 64'd0);
    chk("async_inReady", 64'(inReady), 64'd1);
    chk("async_memWrite", 64'(memWrite), 64'd0);
    chk("async_aluResult", 64'(aluResult), 64'd0);
    reset = 0;
    tick();
    outReady = 1;
    tick();
    chk("after_reset_empty", 64'(outValid), 64'd0);
    // Wide parameters
    v64 = 1; rd64_in = 64'hFFFF_0000_1234_5678; wr64_in = 6'd33;
    tick();
    v64 = 0;
    chk("p64_valid", 64'(ov64), 64'd1);
    chk("p64_regdata", rd64, 64'hFFFF_0000_1234_5678);
    chk("p64_wreg", 64'(wr64), 64'd33);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register for the 5-stage datapath, successor to the fixed-width, always-load EX/MEM latch. It adds valid/ready flow control with a 2-entry skid buffer, so MEM-side stalls do not combinationally back-propagate. It adds a synchronous flush for branch/exception squash and a registered branch-taken decode. It sits between the ALU/EX stage and the data-memory/MEM stage.

Parameters:
DATA_W, 32, width of aluResult, pc and registerData fields
REG_ADDR_W, 5, width of the destination register index
WB_CTRL_W, 2, width of the WB control bundle

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  squash all held entries; synchronous
inValid  input  1  EX presents a valid instruction
inReady  output  1  block can accept this cycle
memControlInput  input  3  {branch, memRead, memWrite}
wbControlInput  input  WB_CTRL_W  WB control bundle
aluResultInput  input  DATA_W  ALU result
aluZeroInput  input  1  ALU zero flag
pcInput  input  DATA_W  branch target / PC
registerDataInput  input  DATA_W  store data (rt)
writeRegisterInput  input  REG_ADDR_W  destination register
outValid  output  1  output entry is valid
outReady  input  1  MEM stage consumes this cycle
branch, memRead, memWrite  output  1 each  MEM control, gated by outValid
wbControl  output  WB_CTRL_W  WB control, gated by outValid
aluResult  output  DATA_W  held ALU result
aluZero  output  1  held zero flag (1 bit; not widened)
pc  output  DATA_W  held PC/target
registerData  output  DATA_W  held store data
writeRegister  output  REG_ADDR_W  held destination
branchTaken  output  1  outValid & branch & aluZero

Behaviour:
- Storage: main entry (M) drives outputs. Skid entry (S) holds one overflow entry. Each has a valid bit plus full payload.
- Reset (async, any time, including mid-transfer): M.valid=S.valid=0. All payload cleared to 0. All outputs read 0. inReady=1 on the first edge after deassert.
- inReady = !S.valid. It is a pure function of state, with no combinational path from outValid, outReady or inValid.
- Accept = inValid & inReady. Consume = outValid & outReady.
- Each rising edge with flush=0:
  - M empty, or M consumed with S empty: accepted data loads M. Latency is 1 cycle; throughput is 1 per cycle with outReady=1.
  - M consumed with S full: S moves to M. Accepted data cannot occur (inReady=0).
  - M full and not consumed, with accept: data loads S (inReady falls next cycle).
  - M full, S empty, consumed, no accept: M.valid clears.
- Ordering is strict FIFO. No entry is lost or duplicated.
- flush=1 at an edge clears M.valid and S.valid, overriding accept and consume. A same-cycle input is discarded. Payload registers may keep stale data.
- Output gating: branch, memRead, memWrite, wbControl and branchTaken are forced to 0 when outValid=0. This guarantees a bubble never writes memory or the register file.
- Data outputs (aluResult, aluZero, pc, registerData, writeRegister) show M payload and are undefined-but-stable when outValid=0.
- branchTaken is combinational from M register bits only; there is no input-to-output combinational path.
- memControlInput mapping: [2]=branch, [1]=memRead, [0]=memWrite.

Test Plan:
- Reset mid-stream: fill M and S, then pulse reset asynchronously between edges → outValid=0, inReady=1, memWrite=0 immediately; aluResult=0.
- Streaming: outReady=1, inValid=1 for 4 cycles with aluResultInput=1,2,3,4 → aluResult=1,2,3,4 on consecutive cycles, 1 cycle behind input.
- Stall/skid: outReady=0 while sending A=0x10, B=0x20 → inReady=0 after B. Raise outReady → A then B emerge, then inReady=1. Nothing is lost.
- Flush with both full: M=A, S=B, then flush=1 with inValid=1, C → next cycle outValid=0, memWrite=0, wbControl=0; C never appears.
- Branch: memControlInput=3'b100, aluZeroInput=1, pcInput=0x40 → next cycle branchTaken=1, pc=0x40. With aluZeroInput=0 → branchTaken=0.
- Params: DATA_W=64, REG_ADDR_W=6, registerDataInput=0xFFFF_0000_1234_5678, writeRegisterInput=33 → both held intact after one cycle.
